// File: rtl/controlador_estados.sv
// Activity state machine for the tamagotchi core: synchronizes the three push-buttons,
// runs each timed action for DUR tick pulses and locks into MORTO when morreu is reported.
module controlador_estados #(
    parameter logic [7:0] DUR_DORMIR = 8'd40,
    parameter logic [7:0] DUR_COMER  = 8'd8,
    parameter logic [7:0] DUR_AULA   = 8'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_dormir_n,
    input  logic       btn_comer_n,
    input  logic       btn_aula_n,
    input  logic       tick,
    input  logic       morreu,
    output logic [3:0] estado,
    output logic       ocupado,
    output logic [7:0] tempo_restante
);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        DORMINDO   = 3'd1,
        COMENDO    = 3'd2,
        DANDO_AULA = 3'd3,
        MORTO      = 3'd4
    } estado_t;

    estado_t    state_r;
    logic [2:0] btn_s;
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] hist_r;
    logic [2:0] press_s;
    logic       cancel_s;
    logic       expira_s;

    // Bit order for all key vectors: [0] dormir, [1] comer, [2] aula.
    assign btn_s = {btn_aula_n, btn_comer_n, btn_dormir_n};

    function automatic logic [3:0] codigo(input estado_t s);
        logic [3:0] c;
        case (s)
            OCIOSO:     c = 4'b0000;
            DORMINDO:   c = 4'b0001;
            COMENDO:    c = 4'b0010;
            DANDO_AULA: c = 4'b0100;
            MORTO:      c = 4'b1000;
            default:    c = 4'b0000;
        endcase
        return c;
    endfunction

    // Two-flop synchronizer plus history flop; released level out of reset blocks spurious presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            hist_r  <= 3'b111;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Press pulses, same-key cancel and last-tick detection.
    always_comb begin
        press_s  = ~sync2_r & hist_r;
        cancel_s = 1'b0;
        expira_s = tick && (tempo_restante == 8'd1);
        case (state_r)
            DORMINDO:   cancel_s = press_s[0];
            COMENDO:    cancel_s = press_s[1];
            DANDO_AULA: cancel_s = press_s[2];
            default:    cancel_s = 1'b0;
        endcase
    end

    // Activity FSM with registered estado/ocupado/tempo_restante.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= OCIOSO;
            estado         <= 4'b0000;
            ocupado        <= 1'b0;
            tempo_restante <= 8'd0;
        end else if (morreu) begin
            state_r        <= MORTO;
            estado         <= codigo(MORTO);
            ocupado        <= 1'b0;
            tempo_restante <= 8'd0;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (press_s[0]) begin
                        state_r        <= DORMINDO;
                        estado         <= codigo(DORMINDO);
                        ocupado        <= 1'b1;
                        tempo_restante <= DUR_DORMIR;
                    end else if (press_s[1]) begin
                        state_r        <= COMENDO;
                        estado         <= codigo(COMENDO);
                        ocupado        <= 1'b1;
                        tempo_restante <= DUR_COMER;
                    end else if (press_s[2]) begin
                        state_r        <= DANDO_AULA;
                        estado         <= codigo(DANDO_AULA);
                        ocupado        <= 1'b1;
                        tempo_restante <= DUR_AULA;
                    end else begin
                        state_r        <= OCIOSO;
                        estado         <= codigo(OCIOSO);
                        ocupado        <= 1'b0;
                        tempo_restante <= 8'd0;
                    end
                end
                DORMINDO, COMENDO, DANDO_AULA: begin
                    if (cancel_s || expira_s) begin
                        state_r        <= OCIOSO;
                        estado         <= codigo(OCIOSO);
                        ocupado        <= 1'b0;
                        tempo_restante <= 8'd0;
                    end else if (tick && (tempo_restante > 8'd1)) begin
                        tempo_restante <= tempo_restante - 8'd1;
                    end else begin
                        tempo_restante <= tempo_restante;
                    end
                end
                MORTO: begin
                    state_r        <= MORTO;
                    estado         <= codigo(MORTO);
                    ocupado        <= 1'b0;
                    tempo_restante <= 8'd0;
                end
                default: begin
                    state_r        <= OCIOSO;
                    estado         <= codigo(OCIOSO);
                    ocupado        <= 1'b0;
                    tempo_restante <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_estados.sv
// Bench for controlador_estados: directed scenarios plus random keys/ticks, compared every
// cycle against an activity/countdown model with a three-sample key delay line.
module tb_controlador_estados;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_dormir_n = 1'b1;
    logic       btn_comer_n = 1'b1;
    logic       btn_aula_n = 1'b1;
    logic       tick = 1'b0;
    logic       morreu = 1'b0;
    logic [3:0] estado;
    logic       ocupado;
    logic [7:0] tempo_restante;

    int checks = 0;
    int failures = 0;

    // model: mode 0 idle, 1 dormir, 2 comer, 3 aula, 4 morto
    int         m_mode = 0;
    int         m_rem = 0;
    logic [2:0] h0 = 3'b111;
    logic [2:0] h1 = 3'b111;
    logic [2:0] h2 = 3'b111;
    int         dur [1:3] = '{40, 8, 16};

    controlador_estados dut (
        .clk(clk), .rst_n(rst_n),
        .btn_dormir_n(btn_dormir_n), .btn_comer_n(btn_comer_n), .btn_aula_n(btn_aula_n),
        .tick(tick), .morreu(morreu),
        .estado(estado), .ocupado(ocupado), .tempo_restante(tempo_restante)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0;
        h0 = 3'b111; h1 = 3'b111; h2 = 3'b111;
    endtask

    task automatic model_edge();
        logic [2:0] pr;
        pr = ~h1 & h2;
        if (morreu) begin
            m_mode = 4; m_rem = 0;
        end else if (m_mode == 0) begin
            for (int k = 0; k < 3; k++) begin
                if (m_mode == 0 && pr[k]) begin
                    m_mode = k + 1; m_rem = dur[k + 1];
                end
            end
        end else if (m_mode >= 1 && m_mode <= 3) begin
            if (pr[m_mode - 1]) begin
                m_mode = 0; m_rem = 0;
            end else if (tick) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = 0;
            end
        end
        h2 = h1; h1 = h0;
        h0 = {btn_aula_n, btn_comer_n, btn_dormir_n};
    endtask

    task automatic check_model();
        logic [7:0] e;
        e = (m_mode == 0) ? 8'd0 : (8'd1 << (m_mode - 1));
        chk("estado", {4'd0, estado}, e);
        chk("ocupado", {7'd0, ocupado}, {7'd0, (m_mode >= 1 && m_mode <= 3)});
        chk("tempo_restante", tempo_restante, m_rem[7:0]);
    endtask

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_model();
        end
    endtask

    task automatic tick_until_idle();
        int guard;
        guard = 0;
        while (m_mode != 0 && guard < 300) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
            guard++;
        end
        chk("idle_wait", {4'd0, estado}, 8'h00);
    endtask

    initial begin
        // reset and quiet keys
        #12;
        chk("rst_estado", {4'd0, estado}, 8'h00);
        chk("rst_tempo", tempo_restante, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        cycle(20);

        // comer: 8 ticks, 5 cycles apart
        btn_comer_n = 1'b0;
        cycle(2);
        chk("comer_lat_before", {4'd0, estado}, 8'h00);
        cycle();
        chk("comer_lat", {4'd0, estado}, 8'h02);
        chk("comer_load", tempo_restante, 8'd8);
        btn_comer_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle(4);
        end
        chk("comer_end", {4'd0, estado}, 8'h00);
        chk("comer_end_tempo", tempo_restante, 8'h00);

        // hold dormir, aula ignored, re-press cancels
        btn_dormir_n = 1'b0;
        cycle(100);
        chk("hold_dormir", {4'd0, estado}, 8'h01);
        btn_dormir_n = 1'b1; cycle(5);
        btn_aula_n = 1'b0; cycle(3);
        btn_aula_n = 1'b1; cycle(5);
        chk("aula_ignored", {4'd0, estado}, 8'h01);
        btn_dormir_n = 1'b0; cycle(5);
        chk("cancel_dormir", {4'd0, estado}, 8'h00);
        btn_dormir_n = 1'b1; cycle(5);

        // simultaneous presses: dormir wins
        btn_dormir_n = 1'b0; btn_comer_n = 1'b0; btn_aula_n = 1'b0;
        cycle(5);
        chk("prio_estado", {4'd0, estado}, 8'h01);
        chk("prio_tempo", tempo_restante, 8'd40);
        btn_dormir_n = 1'b1; btn_comer_n = 1'b1; btn_aula_n = 1'b1;
        cycle(5);
        btn_dormir_n = 1'b0; cycle(4);
        btn_dormir_n = 1'b1; cycle(4);

        // random keys and ticks
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) btn_dormir_n = ~btn_dormir_n;
            if ($urandom_range(0, 9) == 0) btn_comer_n = ~btn_comer_n;
            if ($urandom_range(0, 9) == 0) btn_aula_n = ~btn_aula_n;
            tick = ($urandom_range(0, 2) == 0);
            cycle();
        end
        btn_dormir_n = 1'b1; btn_comer_n = 1'b1; btn_aula_n = 1'b1; tick = 1'b0;
        cycle(5);
        tick_until_idle();

        // asynchronous reset in the middle of DANDO_AULA
        btn_aula_n = 1'b0; cycle(3);
        btn_aula_n = 1'b1;
        tick = 1'b1; cycle(); tick = 1'b0; cycle();
        chk("aula_running", tempo_restante, 8'd15);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_estado", {4'd0, estado}, 8'h00);
        chk("async_rst_ocupado", {7'd0, ocupado}, 8'h00);
        chk("async_rst_tempo", tempo_restante, 8'h00);
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cycle(3);
        btn_comer_n = 1'b0; cycle(3);
        chk("fresh_comer", tempo_restante, 8'd8);
        btn_comer_n = 1'b1; cycle(4);
        btn_comer_n = 1'b0; cycle(4);
        btn_comer_n = 1'b1; cycle(4);

        // death during DANDO_AULA with simultaneous tick and aula press
        btn_aula_n = 1'b0; cycle(3);
        btn_aula_n = 1'b1; cycle(4);
        btn_aula_n = 1'b0; cycle(2);
        morreu = 1'b1; tick = 1'b1;
        cycle();
        chk("death", {4'd0, estado}, 8'h08);
        morreu = 1'b0; tick = 1'b0; btn_aula_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            btn_dormir_n = $urandom_range(0, 1);
            btn_comer_n = $urandom_range(0, 1);
            btn_aula_n = $urandom_range(0, 1);
            tick = $urandom_range(0, 1);
            cycle();
        end
        chk("morto_absorbing", {4'd0, estado}, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_estados.md
# controlador_estados

Upstream activity state machine for the tamagotchi core: turns the three board push-buttons into the one-hot `estado` code consumed by `controlador_atributos`. Each action (dormir, comer, dar aula) runs for a fixed number of `tick` pulses, then the block returns to idle. When `controlador_atributos` reports `morreu`, the block locks into MORTO until reset.

## Interface
- `DUR_DORMIR`, 8'd40: number of `tick` pulses spent in DORMINDO; legal range 1..255.
- `DUR_COMER`, 8'd8: number of `tick` pulses spent in COMENDO; legal range 1..255.
- `DUR_AULA`, 8'd16: number of `tick` pulses spent in DANDO_AULA; legal range 1..255.
- `clk` input 1: single system clock; everything is posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_dormir_n` input 1: raw board key, active-low, asynchronous to `clk`.
- `btn_comer_n` input 1: raw board key, active-low, asynchronous to `clk`.
- `btn_aula_n` input 1: raw board key, active-low, asynchronous to `clk`.
- `tick` input 1: one-cycle time-base strobe in the `clk` domain.
- `morreu` input 1: death flag from `controlador_atributos`, level, in the `clk` domain.
- `estado` output 4: registered one-hot activity code.
- `ocupado` output 1: registered; high in DORMINDO, COMENDO or DANDO_AULA.
- `tempo_restante` output 8: registered count of `tick` pulses left in the current action.

## Operation
- States and `estado` encodings: OCIOSO 4'b0000, DORMINDO 4'b0001, COMENDO 4'b0010, DANDO_AULA 4'b0100, MORTO 4'b1000.
- Reset values: `estado`=4'b0000, `ocupado`=0, `tempo_restante`=0. All synchronizer flops reset to 1 (released), so no press is detected out of reset.
- Input conditioning: each key goes through a 2-flop synchronizer, then a history flop. A press is a 1-cycle pulse, asserted when the synchronized level is 0 and the history flop is 1. Holding a key produces exactly one press.
- From OCIOSO, a press moves to the matching action and loads `tempo_restante` with that action's DUR parameter.
- Simultaneous presses in OCIOSO resolve with priority dormir > comer > aula.
- Inside an action:
  - Each `tick` with `tempo_restante`>1 decrements `tempo_restante`.
  - A `tick` with `tempo_restante`==1 moves to OCIOSO and sets `tempo_restante` to 0.
  - The action therefore lasts exactly DUR `tick` pulses.
- Inside an action, pressing the same action's key cancels it: go to OCIOSO, `tempo_restante`=0. Presses of other keys are ignored and are not queued.
- A cancel press and an expiring `tick` in the same cycle both lead to OCIOSO with `tempo_restante`=0.
- `morreu`=1 in any state moves the block to MORTO on the next edge. This overrides presses and ticks in the same cycle.
- MORTO is absorbing: `tempo_restante`=0, `ocupado`=0, and all inputs are ignored. Only `rst_n` leaves MORTO.
- `tick` has no effect in OCIOSO or MORTO.
- Reset asserted mid-action forces the reset values immediately (asynchronously). On release, the block starts in OCIOSO.

## Timing
- Press latency: with a key low ahead of edge k, the sync1 flop is 0 after k and the sync2 flop is 0 after k+1. The press pulse is high during cycle k+1..k+2, and `estado`/`tempo_restante` update at edge k+2.
- Tick response: a `tick` sampled at edge n updates `tempo_restante` and state at edge n; the result is visible in the following cycle.
- Death response: `morreu` sampled at edge n gives `estado`=4'b1000 after edge n.
- `ocupado` is registered alongside `estado` and never disagrees with it in any cycle.
- `tempo_restante` is 8-bit unsigned and never wraps: it is decremented only when >1.

## Test plan
- Reset, then hold all keys released for 20 cycles -> `estado`=0000, `ocupado`=0, `tempo_restante`=0 throughout.
- Press comer (DUR_COMER=8), then send 8 ticks spaced 5 cycles apart:
  - `estado`=0010 appears at the 3rd edge after the key goes low.
  - `tempo_restante` steps 8→7→…→1.
  - After the 8th tick, `estado`=0000 and `tempo_restante`=0.
- Hold the dormir key low for 100 cycles during DORMINDO, release it, and press again:
  - Holding produces only one transition.
  - The re-press cancels: `estado`=0000.
  - An aula press during DORMINDO leaves `estado`=0001.
- Press all three keys in the same cycle from OCIOSO -> `estado`=0001, `tempo_restante`=40.
- Mid-DANDO_AULA, assert `morreu` together with a `tick` and an aula press -> `estado`=1000 at the next edge. Further presses and ticks keep `estado` at 1000.
- Pulse `rst_n` low asynchronously (between edges) mid-action -> outputs go to their reset values at once. After release, a new press starts a fresh action with a full DUR load.
